// File: rtl/hld_pkg.sv
// Shared types for the multi-tap harmonic/false-lock detector.
package hld_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLDOFF = 3'd1,
    ACQ     = 3'd2,
    LOCKED  = 3'd3,
    RST_PD  = 3'd4
  } hld_state_e;

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_STUCK = 2'b01;
  localparam logic [1:0] FAULT_HARM  = 2'b10;

endpackage

// File: rtl/hld_multi_if.sv
// Detector control/status bundle: master drives enable and taps, slave reports status.
interface hld_multi_if #(
  parameter int NTAP    = 8,
  parameter int RETRY_W = 4
);
  localparam int CW = $clog2(NTAP);

  logic                en;
  logic                sample_vld;
  logic [NTAP-1:0]     taps;
  logic                reset_pd_n;
  logic                locked;
  logic [1:0]          last_fault;
  logic [CW-1:0]       edge_cnt;
  logic [RETRY_W-1:0]  retry_cnt;

  modport master (
    output en, sample_vld, taps,
    input  reset_pd_n, locked, last_fault, edge_cnt, retry_cnt
  );

  modport slave (
    input  en, sample_vld, taps,
    output reset_pd_n, locked, last_fault, edge_cnt, retry_cnt
  );
endinterface

// File: rtl/hld_edge_cnt.sv
// Counts rising transitions (tap i low, tap i+1 high) across adjacent taps.
module hld_edge_cnt #(
  parameter int NTAP = 8,
  parameter int CW   = $clog2(NTAP)
) (
  input  logic [NTAP-1:0] taps_i,
  output logic [CW-1:0]   cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < NTAP-1; i++)
      if (!taps_i[i] && taps_i[i+1]) cnt_o = cnt_o + CW'(1);
  end
endmodule

// File: rtl/hld_multi.sv
// Harmonic/false-lock detector: two-stage tap pipeline feeding a lock/fault FSM
// that pulses the phase-detector reset on a confirmed stuck or harmonic condition.
module hld_multi
  import hld_pkg::*;
#(
  parameter int NTAP     = 8,
  parameter int CONFIRM  = 4,
  parameter int LOCK_CNT = 16,
  parameter int RST_LEN  = 4,
  parameter int HOLD     = 64,
  parameter int RETRY_W  = 4
) (
  input  logic         clk,
  input  logic         rst,
  hld_multi_if.slave   bus
);
  localparam int CW   = $clog2(NTAP);
  localparam int GW   = $clog2(LOCK_CNT + 1);
  localparam int BW   = $clog2(CONFIRM + 1);
  localparam int TMAX = (HOLD > RST_LEN) ? HOLD : RST_LEN;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_CNT);
  localparam logic [BW-1:0] BAD_MAX   = BW'(CONFIRM);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD - 1);
  localparam logic [TW-1:0] RST_LAST  = TW'(RST_LEN - 1);

  logic [NTAP-1:0]    taps_q;
  logic               v1_q, v2_q;
  logic [CW-1:0]      edge_cnt_q, cnt_w;

  hld_state_e         state_q, state_d;
  logic [GW-1:0]      good_q, good_d;
  logic [BW-1:0]      bad_q, bad_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic               pd_n_q, pd_n_d;
  logic               locked_q, locked_d;
  logic [1:0]         fault_q, fault_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               good;

  hld_edge_cnt #(.NTAP(NTAP), .CW(CW)) u_edge_cnt (
    .taps_i (taps_q),
    .cnt_o  (cnt_w)
  );

  // edge_cnt holds the count of the last valid sample, so it only loads behind v1
  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q     <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      v1_q <= bus.sample_vld;
      v2_q <= v1_q;
      if (bus.sample_vld) taps_q     <= bus.taps;
      if (v1_q)           edge_cnt_q <= cnt_w;
    end
  end

  assign good = (edge_cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    tmr_d   = tmr_q;
    fault_d = fault_q;
    retry_d = retry_q;
    if (!bus.en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = HOLDOFF;
        HOLDOFF: begin
          tmr_d = tmr_q + 1'b1;
          if (tmr_q == HOLD_LAST) state_d = ACQ;
        end
        ACQ: if (v2_q) begin
          if (good) begin
            bad_d = '0;
            if (good_q != GOOD_MAX) good_d = good_q + 1'b1;
            if (good_d == GOOD_MAX) state_d = LOCKED;
          end else begin
            good_d = '0;
            if (bad_q != BAD_MAX) bad_d = bad_q + 1'b1;
            if (bad_d == BAD_MAX) state_d = RST_PD;
          end
        end
        LOCKED: if (v2_q) begin
          if (good) begin
            bad_d = '0;
          end else begin
            if (bad_q != BAD_MAX) bad_d = bad_q + 1'b1;
            if (bad_d == BAD_MAX) state_d = RST_PD;
          end
        end
        RST_PD: begin
          tmr_d = tmr_q + 1'b1;
          if (tmr_q == RST_LAST) state_d = HOLDOFF;
        end
        default: state_d = IDLE;
      endcase
    end
    // fault classification uses the sample that confirmed the fault
    if (state_d == RST_PD && state_q != RST_PD) begin
      fault_d = (edge_cnt_q == '0) ? FAULT_STUCK : FAULT_HARM;
      if (retry_q != '1) retry_d = retry_q + 1'b1;
    end
    if (state_d == LOCKED && state_q != LOCKED) fault_d = FAULT_NONE;
    if (state_d != state_q) begin
      good_d = '0;
      bad_d  = '0;
      tmr_d  = '0;
    end
    pd_n_d   = (state_d != RST_PD);
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      good_q   <= '0;
      bad_q    <= '0;
      tmr_q    <= '0;
      pd_n_q   <= 1'b1;
      locked_q <= 1'b0;
      fault_q  <= FAULT_NONE;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      tmr_q    <= tmr_d;
      pd_n_q   <= pd_n_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
      retry_q  <= retry_d;
    end
  end

  assign bus.reset_pd_n = pd_n_q;
  assign bus.locked     = locked_q;
  assign bus.last_fault = fault_q;
  assign bus.edge_cnt   = edge_cnt_q;
  assign bus.retry_cnt  = retry_q;

endmodule

// File: doc/hld_multi.md
Name: hld_multi

Overview:
Parametrised harmonic/false-lock detector for the DLL. It is the successor to the two-window harmonic lock detector. Each sample evaluates a snapshot of all NTAP delay-line taps and counts rising transitions across adjacent taps:
- exactly one transition = correct lock;
- zero transitions = stuck;
- more than one transition = harmonic lock.

A confirmed fault drives an active-low phase-detector reset pulse, then a settle hold-off. The block also reports lock status, the last fault type and a retry count.

Parameters:
NTAP, 8, number of delay-line taps sampled (>=3)
CONFIRM, 4, consecutive bad samples needed to declare a fault (>=1)
LOCK_CNT, 16, consecutive good samples needed to declare lock (>=1)
RST_LEN, 4, reset_pd_n low width in clk cycles (>=1)
HOLD, 64, settle cycles after enable or after a PD reset, with samples ignored (>=1)
RETRY_W, 4, retry counter width

Ports:
clk  in  1  single clock (reference domain)
rst  in  1  synchronous reset, active-high
en  in  1  detector enable
sample_vld  in  1  taps valid this cycle
taps  in  NTAP  delay-line tap snapshot, already synchronised to clk
reset_pd_n  out  1  active-low phase-detector reset
locked  out  1  lock indication
last_fault  out  2  00 none, 01 stuck, 10 harmonic
edge_cnt  out  $clog2(NTAP)  registered transition count of the last sample
retry_cnt  out  RETRY_W  PD resets issued, saturating

Behaviour:
- Reset values (rst high at a clk edge):
  - state=IDLE, reset_pd_n=1, locked=0, last_fault=00, edge_cnt=0, retry_cnt=0.
  - All internal counters and pipeline valids are cleared.
  - rst has priority over everything.
- Pipeline:
  - Edge E: sample_vld=1 → taps captured into taps_q, v1=1.
  - Edge E+1: edge_cnt = count of i in 0..NTAP-2 with taps_q[i]=0 and taps_q[i+1]=1; v2=v1.
  - Edge E+2: FSM acts on v2/edge_cnt.
  - good = (edge_cnt==1); bad = otherwise.
- FSM states: IDLE, HOLDOFF, ACQ, LOCKED, RST_PD.
  - IDLE: outputs inactive. If en=1 → HOLDOFF with hold counter=0.
  - HOLDOFF: hold counter counts HOLD cycles, then → ACQ. Samples are ignored, and good_cnt and bad_cnt are held at 0.
  - ACQ, when a sample is evaluated:
    - good: good_cnt++, bad_cnt=0.
    - bad: bad_cnt++, good_cnt=0.
    - good_cnt reaches LOCK_CNT → LOCKED; locked=1 from that edge; last_fault=00.
    - bad_cnt reaches CONFIRM → RST_PD.
  - LOCKED:
    - good clears bad_cnt.
    - bad increments bad_cnt.
    - bad_cnt reaches CONFIRM → RST_PD; locked=0 at that same edge.
  - RST_PD:
    - reset_pd_n=0 for exactly RST_LEN cycles, then → HOLDOFF.
    - On entry: last_fault = 01 if edge_cnt==0, else 10; retry_cnt increments, saturating at all-ones.
- Counters: good_cnt and bad_cnt saturate at their thresholds, never wrap. Both clear on every state change.
- Simultaneous events: if sample_vld arrives while in HOLDOFF, RST_PD or IDLE, the pipeline still runs and edge_cnt updates, but the FSM ignores the result.
- en=0 in any state → IDLE at the next edge:
  - reset_pd_n returns high immediately, even mid-pulse;
  - locked drops;
  - last_fault and retry_cnt are retained.
- Enable toggling: en re-asserted restarts from HOLDOFF.
- reset_pd_n is registered and glitch-free.

Decomposition:
- Package hld_pkg:
  - state enum (IDLE, HOLDOFF, ACQ, LOCKED, RST_PD);
  - fault codes FAULT_NONE=2'b00, FAULT_STUCK=2'b01, FAULT_HARM=2'b10.
- Sub-module hld_edge_cnt: parametrised NTAP, a combinational adjacent-rising-transition popcount. It is instanced once, between taps_q and the edge_cnt register.
- FSM, counters and output registers stay in hld_multi.

Test Plan:
- Reset and enable:
  - rst=1 for 2 cycles → all outputs at their reset values.
  - en=1, no samples → after HOLD=64 cycles state=ACQ, reset_pd_n=1.
- Correct lock:
  - NTAP=8, taps=8'b11110000 every cycle → edge_cnt=1.
  - locked=1 on the edge after the 16th evaluated sample.
  - last_fault=00, retry_cnt=0.
- Harmonic fault:
  - taps=8'b11001100 (2 transitions) in ACQ → edge_cnt=2.
  - After the 4th sample, reset_pd_n=0 for exactly 4 cycles.
  - last_fault=10, retry_cnt=1, then 64 HOLDOFF cycles.
- Stuck fault and glitch tolerance:
  - In LOCKED, taps=8'hFF for 3 samples then 8'b11110000 → no reset, locked stays 1.
  - 4 consecutive 8'hFF samples → locked=0, reset_pd_n pulses, last_fault=01.
- Retry saturation: 17 forced harmonic faults with RETRY_W=4 → retry_cnt=15 and holds.
- Mid-pulse disable: en=0 during the 2nd RST_PD cycle → reset_pd_n=1 and state IDLE next edge; last_fault and retry_cnt retained.
